// File: rtl/d20_roll_arbiter.sv
// d20_roll_arbiter
//   Shares one d20 roll unit among NUM_REQ requesters. Requests are picked
//   round-robin. Each request gets one roll, or two in advantage mode, where
//   the higher signed final value is kept. A WAIT that lasts TIMEOUT cycles
//   aborts the request. The result goes back to the granted requester with a
//   one-cycle resp_valid pulse.
//
// Ports
//   clk, reset      clock; asynchronous active-high reset
//   req/req_adv     per-requester level request and advantage flag
//   req_mod/target  packed signed modifiers and targets, slot i at [i*NUM_BITS +: NUM_BITS]
//   roll_*  (out)   start pulse, modifier and target sent to the roll unit
//   roll_*  (in)    done strobe, raw roll, final value and hit flag from the roll unit
//   grant, busy     one-hot requester being served; high whenever not IDLE
//   resp_*          registered result; valid for one cycle, fields held until the next result
module d20_roll_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_BITS = 8,
  parameter int TIMEOUT  = 64,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_adv,
  input  logic [NUM_REQ*NUM_BITS-1:0]  req_mod,
  input  logic [NUM_REQ*NUM_BITS-1:0]  req_target,
  output logic                         roll_req,
  output logic [NUM_BITS-1:0]          roll_mod,
  output logic [NUM_BITS-1:0]          roll_target,
  input  logic                         roll_done,
  input  logic [4:0]                   roll_value,
  input  logic [NUM_BITS-1:0]          roll_final,
  input  logic                         roll_hit,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         busy,
  output logic                         resp_valid,
  output logic [ID_W-1:0]              resp_id,
  output logic [4:0]                   resp_value,
  output logic [NUM_BITS-1:0]          resp_final,
  output logic                         resp_hit,
  output logic                         resp_timeout
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                r_state;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [ID_W-1:0]       r_id;
  logic                  r_adv;
  logic                  r_second;      // the roll in flight is the second of an advantage pair
  logic [TMR_W-1:0]      r_timer;
  logic [4:0]            r_first_value;
  logic [NUM_BITS-1:0]   r_first_final;
  logic                  r_first_hit;

  logic                  r_roll_req;
  logic [NUM_BITS-1:0]   r_roll_mod;
  logic [NUM_BITS-1:0]   r_roll_target;
  logic [NUM_REQ-1:0]    r_grant;
  logic                  r_busy;
  logic                  r_resp_valid;
  logic [ID_W-1:0]       r_resp_id;
  logic [4:0]            r_resp_value;
  logic [NUM_BITS-1:0]   r_resp_final;
  logic                  r_resp_hit;
  logic                  r_resp_timeout;

  // Unpack the per-slot modifier and target fields.
  logic [NUM_BITS-1:0]   w_mod_slot [NUM_REQ];
  logic [NUM_BITS-1:0]   w_tgt_slot [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_mod_slot[gi] = req_mod[gi*NUM_BITS +: NUM_BITS];
    assign w_tgt_slot[gi] = req_target[gi*NUM_BITS +: NUM_BITS];
  end

  // Round-robin pick. The loop scans from the highest offset down, so the
  // last hit is the set bit nearest to r_rr_ptr, searching upward with wrap.
  logic                  w_sel_valid;
  logic [ID_W-1:0]       w_sel_id;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[ID_W'((int'(r_rr_ptr) + i) % NUM_REQ)]) begin
        w_sel_valid = 1'b1;
        w_sel_id    = ID_W'((int'(r_rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  // In advantage mode the second roll replaces the first only if it is
  // strictly larger, so a tie keeps the first roll.
  logic w_second_wins;
  assign w_second_wins = $signed(roll_final) > $signed(r_first_final);

  logic [NUM_REQ-1:0] w_one;
  assign w_one = NUM_REQ'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_rr_ptr       <= '0;
      r_id           <= '0;
      r_adv          <= 1'b0;
      r_second       <= 1'b0;
      r_timer        <= '0;
      r_first_value  <= '0;
      r_first_final  <= '0;
      r_first_hit    <= 1'b0;
      r_roll_req     <= 1'b0;
      r_roll_mod     <= '0;
      r_roll_target  <= '0;
      r_grant        <= '0;
      r_busy         <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_resp_id      <= '0;
      r_resp_value   <= '0;
      r_resp_final   <= '0;
      r_resp_hit     <= 1'b0;
      r_resp_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_sel_valid) begin
            r_id          <= w_sel_id;
            r_adv         <= req_adv[w_sel_id];
            r_roll_mod    <= w_mod_slot[w_sel_id];
            r_roll_target <= w_tgt_slot[w_sel_id];
            r_second      <= 1'b0;
            r_grant       <= w_one << w_sel_id;
            r_busy        <= 1'b1;
            r_roll_req    <= 1'b1;   // high during the coming ISSUE cycle
            r_state       <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          r_roll_req <= 1'b0;
          r_timer    <= '0;
          r_state    <= S_WAIT;
        end

        S_WAIT: begin
          r_timer <= r_timer + TMR_W'(1);
          if (roll_done && r_adv && !r_second) begin
            r_first_value <= roll_value;
            r_first_final <= roll_final;
            r_first_hit   <= roll_hit;
            r_second      <= 1'b1;
            r_roll_req    <= 1'b1;
            r_state       <= S_ISSUE;
          end else if (roll_done) begin
            // A result that arrives on the expiry cycle beats the timeout.
            r_resp_valid   <= 1'b1;
            r_resp_id      <= r_id;
            r_resp_timeout <= 1'b0;
            if (r_second && !w_second_wins) begin
              r_resp_value <= r_first_value;
              r_resp_final <= r_first_final;
              r_resp_hit   <= r_first_hit;
            end else begin
              r_resp_value <= roll_value;
              r_resp_final <= roll_final;
              r_resp_hit   <= roll_hit;
            end
            r_state <= S_RESP;
          end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
            // An aborted request reports zeros, even if a first advantage
            // roll was already stored.
            r_resp_valid   <= 1'b1;
            r_resp_id      <= r_id;
            r_resp_timeout <= 1'b1;
            r_resp_value   <= '0;
            r_resp_final   <= '0;
            r_resp_hit     <= 1'b0;
            r_state        <= S_RESP;
          end
        end

        S_RESP: begin
          r_resp_valid <= 1'b0;
          r_grant      <= '0;
          r_busy       <= 1'b0;
          r_rr_ptr     <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + ID_W'(1);
          r_state      <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign roll_req     = r_roll_req;
  assign roll_mod     = r_roll_mod;
  assign roll_target  = r_roll_target;
  assign grant        = r_grant;
  assign busy         = r_busy;
  assign resp_valid   = r_resp_valid;
  assign resp_id      = r_resp_id;
  assign resp_value   = r_resp_value;
  assign resp_final   = r_resp_final;
  assign resp_hit     = r_resp_hit;
  assign resp_timeout = r_resp_timeout;

endmodule

// File: tb/tb_d20_roll_arbiter.sv
// Testbench for d20_roll_arbiter (NUM_REQ=4, NUM_BITS=8, TIMEOUT=8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_d20_roll_arbiter;

  localparam int NR = 4;
  localparam int NB = 8;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NR-1:0]  req = '0;
  logic [NR-1:0]  req_adv = '0;
  logic [NR*NB-1:0] req_mod = '0;
  logic [NR*NB-1:0] req_target = '0;
  logic           roll_req;
  logic [NB-1:0]  roll_mod;
  logic [NB-1:0]  roll_target;
  logic           roll_done = 1'b0;
  logic [4:0]     roll_value = '0;
  logic [NB-1:0]  roll_final = '0;
  logic           roll_hit = 1'b0;
  logic [NR-1:0]  grant;
  logic           busy;
  logic           resp_valid;
  logic [1:0]     resp_id;
  logic [4:0]     resp_value;
  logic [NB-1:0]  resp_final;
  logic           resp_hit;
  logic           resp_timeout;

  int checks = 0;
  int errors = 0;
  int n_roll_req = 0;
  int n_resp = 0;

  d20_roll_arbiter #(.NUM_REQ(NR), .NUM_BITS(NB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_adv(req_adv),
    .req_mod(req_mod), .req_target(req_target),
    .roll_req(roll_req), .roll_mod(roll_mod), .roll_target(roll_target),
    .roll_done(roll_done), .roll_value(roll_value), .roll_final(roll_final), .roll_hit(roll_hit),
    .grant(grant), .busy(busy), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_value(resp_value), .resp_final(resp_final), .resp_hit(resp_hit),
    .resp_timeout(resp_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (roll_req) n_roll_req++;
    if (resp_valid) n_resp++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic set_slot(input int i, input logic [NB-1:0] m, input logic [NB-1:0] t);
    req_mod[i*NB +: NB]    = m;
    req_target[i*NB +: NB] = t;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req = '0; req_adv = '0; req_mod = '0; req_target = '0;
    roll_done = 1'b0;
    tick;
    reset = 1'b0;
  endtask

  // Wait (bounded) for roll_req, then raise roll_done k cycles later for one cycle.
  // On return the bench sits on the falling edge one cycle after roll_done.
  task automatic answer_roll(input int k, input logic [4:0] v, input logic [NB-1:0] f, input logic h);
    int n = 0;
    while (!roll_req && n < 20) begin
      tick;
      n++;
    end
    if (!roll_req) begin
      checks++; errors++;
      $display("FAIL roll_req_wait: roll_req=%0b after %0d cycles, required 1", roll_req, n);
    end else begin
      repeat (k) tick;
      roll_done = 1'b1; roll_value = v; roll_final = f; roll_hit = h;
      tick;
      roll_done = 1'b0; roll_value = '0; roll_final = '0; roll_hit = 1'b0;
    end
  endtask

  task automatic test_reset;
    req = 4'b1111;
    tick;
    checks++;
    if ({grant, busy, roll_req, roll_mod, roll_target, resp_valid, resp_id, resp_value,
         resp_final, resp_hit, resp_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: grant=%b busy=%b roll_req=%b resp_valid=%b, required all 0",
               grant, busy, roll_req, resp_valid);
    end
    reset = 1'b0;
    req = '0;
  endtask

  task automatic test_single_roll;
    do_reset;
    set_slot(0, 8'd3, 8'd15);
    req = 4'b0001;                       // cycle 0
    tick;                                // cycle 1
    checks++;
    if ({roll_req, grant, busy, roll_mod, roll_target} !== {1'b1, 4'b0001, 1'b1, 8'd3, 8'd15}) begin
      errors++;
      $display("FAIL single_issue: roll_req=%b grant=%b busy=%b mod=%h tgt=%h, required 1 0001 1 03 0f",
               roll_req, grant, busy, roll_mod, roll_target);
    end
    tick;                                // cycle 2
    checks++;
    if ({roll_req, grant} !== {1'b0, 4'b0001}) begin
      errors++;
      $display("FAIL single_wait: roll_req=%b grant=%b, required 0 0001", roll_req, grant);
    end
    roll_done = 1'b0;
    tick;                                // cycle 3
    checks++;
    if ({resp_valid, grant} !== {1'b0, 4'b0001}) begin
      errors++;
      $display("FAIL single_early: resp_valid=%b grant=%b, required 0 0001", resp_valid, grant);
    end
    roll_done = 1'b1; roll_value = 5'd14; roll_final = 8'd17; roll_hit = 1'b1;
    tick;                                // cycle 4
    roll_done = 1'b0; roll_value = '0; roll_final = '0; roll_hit = 1'b0;
    checks++;
    if ({resp_valid, resp_id, resp_value, resp_final, resp_hit, resp_timeout, grant} !==
        {1'b1, 2'd0, 5'd14, 8'd17, 1'b1, 1'b0, 4'b0001}) begin
      errors++;
      $display("FAIL single_resp: valid=%b id=%0d value=%0d final=%0d hit=%b to=%b grant=%b, required 1 0 14 17 1 0 0001",
               resp_valid, resp_id, resp_value, resp_final, resp_hit, resp_timeout, grant);
    end
    req = '0;
    tick;                                // cycle 5
    checks++;
    if ({resp_valid, grant, busy, resp_value, resp_final} !== {1'b0, 4'b0000, 1'b0, 5'd14, 8'd17}) begin
      errors++;
      $display("FAIL single_hold: valid=%b grant=%b busy=%b value=%0d final=%0d, required 0 0000 0 14 17",
               resp_valid, grant, busy, resp_value, resp_final);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_ids [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3, 2'd0, 2'd2};
    do_reset;
    req = 4'b1111;
    for (int j = 0; j < 9; j++) begin
      answer_roll(1, 5'(j + 1), 8'(j + 1), 1'b1);
      checks++;
      if ({resp_valid, resp_id, grant} !== {1'b1, exp_ids[j], 4'b0001 << exp_ids[j]}) begin
        errors++;
        $display("FAIL rr_order[%0d]: valid=%b id=%0d grant=%b, required 1 %0d %b",
                 j, resp_valid, resp_id, grant, exp_ids[j], 4'b0001 << exp_ids[j]);
      end
      if (j == 4) req = 4'b1101;
    end
    req = '0;
    tick;
  endtask

  task automatic test_advantage;
    do_reset;
    set_slot(2, 8'hFE, 8'd10);
    req_adv = 4'b0100;
    req = 4'b0100;
    n_roll_req = 0;
    answer_roll(1, 5'd7, 8'd5, 1'b0);
    answer_roll(2, 5'd15, 8'd12, 1'b1);
    checks++;
    if ({resp_valid, resp_id, resp_value, resp_final, resp_hit, resp_timeout} !==
        {1'b1, 2'd2, 5'd15, 8'd12, 1'b1, 1'b0} || n_roll_req != 2) begin
      errors++;
      $display("FAIL adv_higher: valid=%b id=%0d value=%0d final=%0d hit=%b to=%b pulses=%0d, required 1 2 15 12 1 0 2",
               resp_valid, resp_id, resp_value, resp_final, resp_hit, resp_timeout, n_roll_req);
    end
    checks++;
    if ({roll_mod, roll_target} !== {8'hFE, 8'd10}) begin
      errors++;
      $display("FAIL adv_mod_hold: mod=%h tgt=%h, required fe 0a", roll_mod, roll_target);
    end
    // Tie: first roll kept.
    req = '0; tick; req = 4'b0100;
    answer_roll(1, 5'd10, 8'd8, 1'b0);
    answer_roll(1, 5'd6, 8'd8, 1'b0);
    checks++;
    if ({resp_valid, resp_value, resp_final, resp_hit} !== {1'b1, 5'd10, 8'd8, 1'b0}) begin
      errors++;
      $display("FAIL adv_tie: valid=%b value=%0d final=%0d hit=%b, required 1 10 8 0",
               resp_valid, resp_value, resp_final, resp_hit);
    end
    // First roll larger.
    req = '0; tick; req = 4'b0100;
    answer_roll(1, 5'd14, 8'd12, 1'b1);
    answer_roll(1, 5'd5, 8'd3, 1'b0);
    checks++;
    if ({resp_valid, resp_value, resp_final, resp_hit} !== {1'b1, 5'd14, 8'd12, 1'b1}) begin
      errors++;
      $display("FAIL adv_first: valid=%b value=%0d final=%0d hit=%b, required 1 14 12 1",
               resp_valid, resp_value, resp_final, resp_hit);
    end
    // Signed compare: -1 loses to +2.
    req = '0; tick; req = 4'b0100;
    answer_roll(1, 5'd1, 8'hFF, 1'b0);
    answer_roll(1, 5'd4, 8'd2, 1'b0);
    checks++;
    if ({resp_valid, resp_value, resp_final, resp_hit} !== {1'b1, 5'd4, 8'd2, 1'b0}) begin
      errors++;
      $display("FAIL adv_signed: valid=%b value=%0d final=%h hit=%b, required 1 4 02 0",
               resp_valid, resp_value, resp_final, resp_hit);
    end
    // Second roll never answers: timeout with zeroed fields.
    req = '0; tick; req = 4'b0100;
    answer_roll(1, 5'd20, 8'd18, 1'b1);
    repeat (TO + 1) tick;
    checks++;
    if ({resp_valid, resp_timeout, resp_value, resp_final, resp_hit} !== {1'b1, 1'b1, 5'd0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL adv_timeout: valid=%b to=%b value=%0d final=%0d hit=%b, required 1 1 0 0 0",
               resp_valid, resp_timeout, resp_value, resp_final, resp_hit);
    end
    req = '0; req_adv = '0;
    tick;
  endtask

  task automatic test_timeout;
    int n;
    bit early;
    do_reset;
    set_slot(0, 8'd1, 8'd5);
    req = 4'b0001;
    answer_roll(1, 5'd9, 8'd10, 1'b1);
    checks++;
    if ({resp_valid, resp_value} !== {1'b1, 5'd9}) begin
      errors++;
      $display("FAIL to_prime: valid=%b value=%0d, required 1 9", resp_valid, resp_value);
    end
    req = '0; tick; req = 4'b0001;
    n = 0;
    while (!roll_req && n < 20) begin tick; n++; end
    checks++;
    if (roll_req !== 1'b1) begin
      errors++;
      $display("FAIL to_issue: roll_req=%b, required 1", roll_req);
    end
    early = 1'b0;
    for (int i = 1; i <= TO; i++) begin
      tick;
      if (resp_valid) early = 1'b1;
    end
    tick;   // ISSUE + 9: eight cycles after entering WAIT
    checks++;
    if ({early, resp_valid, resp_id, resp_timeout, resp_value, resp_final, resp_hit} !==
        {1'b0, 1'b1, 2'd0, 1'b1, 5'd0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL timeout_resp: early=%b valid=%b id=%0d to=%b value=%0d final=%0d hit=%b, required 0 1 0 1 0 0 0",
               early, resp_valid, resp_id, resp_timeout, resp_value, resp_final, resp_hit);
    end
    // roll_done on the last WAIT cycle wins over the timeout.
    req = '0; tick; req = 4'b0001;
    answer_roll(TO, 5'd11, 8'd12, 1'b1);
    checks++;
    if ({resp_valid, resp_timeout, resp_value, resp_final, resp_hit} !== {1'b1, 1'b0, 5'd11, 8'd12, 1'b1}) begin
      errors++;
      $display("FAIL timeout_edge: valid=%b to=%b value=%0d final=%0d hit=%b, required 1 0 11 12 1",
               resp_valid, resp_timeout, resp_value, resp_final, resp_hit);
    end
    req = '0;
    tick;
  endtask

  task automatic test_negative;
    do_reset;
    set_slot(3, 8'hF8, 8'hFD);
    req = 4'b1000;
    answer_roll(1, 5'd4, 8'hFC, 1'b0);
    checks++;
    if ({resp_valid, resp_id, resp_value, resp_final, resp_hit, roll_mod, roll_target} !==
        {1'b1, 2'd3, 5'd4, 8'hFC, 1'b0, 8'hF8, 8'hFD}) begin
      errors++;
      $display("FAIL negative: valid=%b id=%0d value=%0d final=%h hit=%b mod=%h tgt=%h, required 1 3 4 fc 0 f8 fd",
               resp_valid, resp_id, resp_value, resp_final, resp_hit, roll_mod, roll_target);
    end
    req = '0;
    tick;
  endtask

  task automatic test_reset_mid_wait;
    int n;
    int resp_before;
    do_reset;
    set_slot(1, 8'd2, 8'd3);
    req = 4'b0010;
    answer_roll(1, 5'd5, 8'd7, 1'b1);
    checks++;
    if ({resp_valid, resp_id} !== {1'b1, 2'd1}) begin
      errors++;
      $display("FAIL rst_prime: valid=%b id=%0d, required 1 1", resp_valid, resp_id);
    end
    req = '0; tick; req = 4'b0010;
    n = 0;
    while (!roll_req && n < 20) begin tick; n++; end
    tick; tick;                          // inside WAIT
    resp_before = n_resp;
    reset = 1'b1;
    #1;
    checks++;
    if ({grant, busy, roll_req, roll_mod, roll_target, resp_valid, resp_id, resp_value,
         resp_final, resp_hit, resp_timeout} !== '0) begin
      errors++;
      $display("FAIL rst_async: grant=%b busy=%b mod=%h value=%0d final=%h, required all 0",
               grant, busy, roll_mod, resp_value, resp_final);
    end
    req = '0;
    tick;
    reset = 1'b0;
    roll_done = 1'b1; roll_value = 5'd19; roll_final = 8'd21; roll_hit = 1'b1;
    tick;
    roll_done = 1'b0; roll_value = '0; roll_final = '0; roll_hit = 1'b0;
    repeat (4) tick;
    checks++;
    if (n_resp != resp_before || busy !== 1'b0 || resp_value !== 5'd0) begin
      errors++;
      $display("FAIL rst_late_done: resp pulses=%0d busy=%b value=%0d, required %0d 0 0",
               n_resp, busy, resp_value, resp_before);
    end
    req = 4'b1111;
    n = 0;
    while (!roll_req && n < 20) begin tick; n++; end
    checks++;
    if ({roll_req, grant} !== {1'b1, 4'b0001}) begin
      errors++;
      $display("FAIL rst_rr_ptr: roll_req=%b grant=%b, required 1 0001", roll_req, grant);
    end
    req = '0;
    repeat (TO + 3) tick;
  endtask

  initial begin
    test_reset;
    test_single_roll;
    test_round_robin;
    test_advantage;
    test_timeout;
    test_negative;
    test_reset_mid_wait;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/d20_roll_arbiter.md
Name: d20_roll_arbiter

Overview:
- Shares one d20 roll unit among NUM_REQ requesters (player/NPC slots). The roll unit takes a modifier and a target and returns a raw roll, a final value and a hit flag.
- Arbitrates round-robin, sequences one or two rolls per request (advantage mode), and enforces a response timeout.
- Returns the chosen result to the granted requester with a one-cycle response pulse.
- Sits between the game-turn logic and the roll datapath.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- NUM_BITS, 8, signed width of modifier, target and final value.
- TIMEOUT, 64, maximum cycles spent in WAIT per roll before aborting (≥2).
- ID_W, $clog2(NUM_REQ), requester index width (derived).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- req  in  NUM_REQ  level request per requester
- req_adv  in  NUM_REQ  advantage flag per requester (roll twice, keep higher)
- req_mod  in  NUM_REQ*NUM_BITS  signed modifiers, slot i at [i*NUM_BITS +: NUM_BITS]
- req_target  in  NUM_REQ*NUM_BITS  signed targets, same packing
- roll_req  out  1  one-cycle start pulse to roll unit
- roll_mod  out  NUM_BITS  signed modifier to roll unit
- roll_target  out  NUM_BITS  signed target to roll unit
- roll_done  in  1  roll unit result valid (one cycle)
- roll_value  in  5  raw roll, 1..20
- roll_final  in  NUM_BITS  signed roll+mod
- roll_hit  in  1  roll_final ≥ target
- grant  out  NUM_REQ  one-hot, the requester being served
- busy  out  1  state ≠ IDLE
- resp_valid  out  1  one-cycle result pulse
- resp_id  out  ID_W  requester index of result
- resp_value  out  5  chosen raw roll
- resp_final  out  NUM_BITS  chosen final value
- resp_hit  out  1  chosen hit
- resp_timeout  out  1  abort flag, qualified by resp_valid

Behaviour:
- Reset (async) drives every output to 0: grant, busy, roll_req, roll_mod, roll_target and all resp_* outputs. It also sets state = IDLE, rr_ptr = 0, clears the first-roll store, and clears the timer.
- Reset mid-operation abandons the transaction silently, with no resp_valid. A late roll_done arriving in IDLE is ignored.
- FSM states: IDLE → ISSUE → WAIT → (ISSUE again for the second advantage roll) → RESP → IDLE.
- IDLE:
  - If req ≠ 0, select the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Latch id, req_adv[id], req_mod[id] and req_target[id]. Clear the roll count. Go to ISSUE.
  - Requester inputs are sampled only here; later changes to req* have no effect on the active transaction.
- ISSUE:
  - roll_req = 1 for exactly this cycle. Clear the timer. Go to WAIT.
  - roll_mod and roll_target hold the latched values throughout ISSUE/WAIT/RESP and retain them in IDLE.
- WAIT (roll_done is honoured only in WAIT; in any other state it is ignored):
  - Timer increments each cycle.
  - If roll_done is high and this is the first roll of an advantage request: store value/final/hit, go to ISSUE.
  - Else if roll_done is high: choose the result and go to RESP.
  - Else if timer == TIMEOUT-1: set timeout, go to RESP.
  - roll_done in the same cycle as timer expiry wins; no timeout is flagged.
- Advantage choice:
  - Keep the roll with the larger signed final; on a tie keep the first.
  - resp_value/final/hit all come from the same roll.
  - If the second roll times out, report the timeout with zeroed result fields; the first roll is discarded.
- RESP:
  - resp_valid = 1 for one cycle. resp_* are registered and hold their values until the next RESP.
  - On timeout, resp_value, resp_final and resp_hit are 0 and resp_timeout = 1.
  - rr_ptr ← (id+1) mod NUM_REQ. Go to IDLE.
- grant is one-hot for the latched id from ISSUE through RESP inclusive, and 0 in IDLE.
- A requester drops req after seeing resp_valid. If req is still high in the following IDLE cycle, it is a new request arbitrated normally; rr_ptr already prevents starvation of other requesters.
- Latency:
  - req seen in IDLE at cycle 0 → roll_req at cycle 1. A roll_done at cycle 1+k (k≥1) → resp_valid at cycle 2+k.
  - Advantage adds one ISSUE cycle plus the second roll's k.
- Arithmetic: all comparisons are signed, NUM_BITS wide. The roll unit is responsible for producing roll_final; this block does not recompute it.

Test Plan:
- Single roll: reset, req=0001, mod=+3, target=15, roll unit answers 2 cycles after roll_req with value=14, final=17, hit=1. Required: roll_req at cycle 1; resp_valid at cycle 4 with id=0, value=14, final=17, hit=1, timeout=0; grant=0001 from cycles 1–4.
- Round-robin: req=1111 held, each served once. Required: resp_id sequence 0,1,2,3,0. Then drop req[1] only: sequence continues 2,3,0,2.
- Advantage: req_adv[2]=1, mod=-2, target=10; rolls return final 5 then 12. Required: two roll_req pulses, resp_final=12, hit=1. With equal finals of 8 and 8, the first roll's value is reported.
- Timeout: TIMEOUT=8, roll_done never asserted. Required: resp_valid exactly 8 cycles after entering WAIT, timeout=1, value/final/hit=0. Also assert roll_done on the expiry cycle: required is a normal result with timeout=0.
- Negative arithmetic: mod=-8, target=-3, roll returns value=4, final=-4, hit=0. Required: resp_final=-4 (0xFC), hit=0.
- Reset mid-WAIT: assert reset while waiting. Required: all outputs 0 immediately, no resp_valid. A late roll_done is ignored. Next request is served from rr_ptr=0.
